hub75_bcm_driver: RTL and testbench
===================================

# hub75_bcm_driver

Parametrised HUB75 LED-panel scan driver with binary-coded-modulation (BCM) colour depth. It reads pixel pairs (upper and lower half-panel) from a synchronous frame-buffer read port and shifts one bit-plane per row into the panel. It then latches the row and lights it for a plane-weighted time. It sits inside the Ethernet system next to the packet datapath and drives the board-level HUB75 pins. It replaces the fixed-size 1-bit-per-channel scanner with configurable width, row count and colour depth.

## Interface
Parameters:
- `COLUMNS`, 64: pixels per row; power of two, ≥2.
- `ROW_ADDR_BITS`, 5: scan-row address width. Scan rows R = 2^ROW_ADDR_BITS; panel height = 2R.
- `COLOR_BITS`, 8: bits per channel in the frame buffer.
- `PLANES`, 6: BCM planes displayed (1..COLOR_BITS). Plane p uses channel bit `COLOR_BITS-PLANES+p`.
- `CLOCK_DIV`, 2: half-period of `hub75io_clk` in `clock` cycles; must be ≥2.
- `BASE_OE_CYCLES`, 16: display time of plane 0. Plane p displays for `BASE_OE_CYCLES<<p`.

Ports:
- `clock`  in  1: sole clock.
- `aresetn`  in  1: reset, synchronous, active-low.
- `enable`  in  1: run request.
- `busy`  out  1: high in every state except IDLE.
- `frame_start`  out  1: one-cycle pulse at the start of each frame.
- `pix_en`  out  1: frame-buffer read strobe.
- `pix_addr`  out  ROW_ADDR_BITS+log2(COLUMNS): `{row, column}`.
- `pix_rdata`  in  6*COLOR_BITS: valid one cycle after `pix_en`. Field order MSB→LSB: upper R, G, B, then lower R, G, B.
- `hub75io_clk`  out  1: panel shift clock.
- `hub75io_r`, `hub75io_g`, `hub75io_b`  out  2 each: bit 0 is the upper half, bit 1 the lower half.
- `hub75io_row`  out  ROW_ADDR_BITS: row address.
- `hub75io_lat`  out  1: latch, active-high.
- `hub75io_oe`  out  1: output enable, active-low (1 = blanked).

## Operation
- All outputs are registered.
- Reset values: `hub75io_oe`=1; everything else 0; state IDLE.
- Let L = 2*CLOCK_DIV.

States:
- **IDLE**: panel blanked, clk low. If `enable`=1, go to PREFETCH with row=0, plane=0.
- **PREFETCH** (1 cycle): `pix_en`=1, `pix_addr`={row,0}. `frame_start`=1 in this cycle only when row=0 and plane=0.
- **SHIFT** (COLUMNS*L cycles): column c occupies slot cycles 0..L-1.
  - Slot cycle 0: the r/g/b outputs take the selected plane bit of the data returned for column c.
  - `hub75io_clk`=1 in slot cycles CLOCK_DIV..L-1, 0 otherwise.
  - In the last cycle of slot c (c<COLUMNS-1): `pix_en`=1, `pix_addr`={row,c+1}.
  - `hub75io_oe` stays 1 throughout.
- **LATCH** (2 cycles): `hub75io_row`=row from the first cycle; `hub75io_lat`=1 in both cycles; clk=0.
- **DISPLAY** (`BASE_OE_CYCLES<<plane` cycles): `hub75io_oe`=0.
  - On exit, increment plane.
  - On plane wrap (PLANES-1→0), increment row.
  - On row wrap (R-1→0), end of frame.
- After DISPLAY:
  - Not end of frame → PREFETCH.
  - End of frame → PREFETCH if `enable`=1, else IDLE.
- r/g/b hold their last shifted value outside SHIFT.

## Timing
- `enable` is sampled only in IDLE and at end of frame. Deasserting it mid-frame completes the frame; there is no early abort.
- Cycles per (row, plane p) = 1 + COLUMNS*L + 2 + (BASE_OE_CYCLES<<p).
- Frame length = R * Σp of the above.
- `frame_start` spacing equals the frame length while `enable` stays high.
- Read latency: exactly one cycle, with no back-pressure. The frame buffer is owned by the caller.
- `aresetn`=0 in any state: next cycle all outputs are at reset values, state IDLE, row/plane/column counters cleared. A partially shifted row is discarded.
- `hub75io_oe` is never 0 in the same cycle as `hub75io_lat`=1 or `hub75io_clk`=1.

## Test plan
Common parameters: COLUMNS=4, ROW_ADDR_BITS=1, COLOR_BITS=4, PLANES=2, CLOCK_DIV=2, BASE_OE_CYCLES=4. With these:
- Plane 0 uses bit 2, plane 1 uses bit 3.
- (row, plane) slot lengths are 23 and 27 cycles.
- Frame length is 100 cycles.

Scenarios:
- Reset, then `enable`=1 for one cycle → `frame_start` pulse the next cycle; `busy`=1. After 100 cycles, `busy`=0 and `hub75io_oe`=1.
- `enable` held high → `frame_start` pulses exactly 100 cycles apart. `hub75io_oe`=0 runs of 4, 8, 4, 8 cycles per frame. `hub75io_row` sequence 0, 0, 1, 1.
- Frame buffer with upper R=0x4 and lower B=0x8 everywhere:
  - Plane 0: `hub75io_r`=01, `hub75io_b`=00.
  - Plane 1: `hub75io_r`=00, `hub75io_b`=10.
  - Each plane gives 4 clk rising edges, with data stable ≥1 cycle before each edge.
- `pix_addr` trace for row 1 → 4, 5, 6, 7, each with `pix_en` exactly one cycle, one per slot.
- `aresetn`=0 during SHIFT of row 1 → next cycle all outputs are at reset values. After release with `enable`=1, the frame restarts at row 0 with `pix_addr`=0.
- `enable` dropped during row 0 → frame completes (`hub75io_row` reaches 1, both planes shown), then IDLE with no further `pix_en`.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver
//
// HUB75 LED-panel scan driver with binary-coded-modulation colour depth.
// For each scan row and each bit-plane it fetches pixel pairs (upper and
// lower half-panel) from a synchronous frame-buffer read port and shifts
// the selected plane bit into the panel. It then latches the row and
// unblanks it for a time proportional to the plane weight.
//
// Ports:
//   clock        sole clock
//   aresetn      synchronous active-low reset
//   enable       run request, sampled in IDLE and at end of frame
//   busy         high whenever the scanner is not idle
//   frame_start  one-cycle pulse on the first fetch of a frame
//   pix_en       frame-buffer read strobe
//   pix_addr     frame-buffer address {row, column}
//   pix_rdata    read data, one cycle after pix_en: {uR,uG,uB,lR,lG,lB}
//   hub75io_clk  panel shift clock
//   hub75io_r/g/b panel colour data, bit 0 upper half, bit 1 lower half
//   hub75io_row  panel row address
//   hub75io_lat  panel latch, active-high
//   hub75io_oe   panel output enable, active-low
module hub75_bcm_driver #(
  parameter int COLUMNS        = 64,
  parameter int ROW_ADDR_BITS  = 5,
  parameter int COLOR_BITS     = 8,
  parameter int PLANES         = 6,
  parameter int CLOCK_DIV      = 2,
  parameter int BASE_OE_CYCLES = 16
) (
  input  logic                                     clock,
  input  logic                                     aresetn,
  input  logic                                     enable,
  output logic                                     busy,
  output logic                                     frame_start,
  output logic                                     pix_en,
  output logic [ROW_ADDR_BITS+$clog2(COLUMNS)-1:0] pix_addr,
  input  logic [6*COLOR_BITS-1:0]                  pix_rdata,
  output logic                                     hub75io_clk,
  output logic [1:0]                               hub75io_r,
  output logic [1:0]                               hub75io_g,
  output logic [1:0]                               hub75io_b,
  output logic [ROW_ADDR_BITS-1:0]                 hub75io_row,
  output logic                                     hub75io_lat,
  output logic                                     hub75io_oe
);

  localparam int COL_W   = $clog2(COLUMNS);
  localparam int L       = 2 * CLOCK_DIV;
  localparam int SLOT_W  = $clog2(L);
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int CNT_W   = $clog2((BASE_OE_CYCLES << (PLANES - 1)) + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(L - 1);
  localparam logic [SLOT_W-1:0]  CLK_HI     = SLOT_W'(CLOCK_DIV);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLUMNS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  state_t               state, next_state;
  logic [ROW_ADDR_BITS-1:0] row, row_n;
  logic [PLANE_W-1:0]   plane, plane_n;
  logic [COL_W-1:0]     col, col_n;
  logic [SLOT_W-1:0]    slot, slot_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CNT_W-1:0]     disp_last;
  logic [5:0]           plane_bits;

  logic                                     busy_d, frame_start_d, pix_en_d;
  logic [ROW_ADDR_BITS+COL_W-1:0]           pix_addr_d;
  logic                                     clk_d, lat_d, oe_d;
  logic [ROW_ADDR_BITS-1:0]                 row_out_d;

  // Pick the current plane's bit out of each of the six colour fields.
  // Index 0 is lower B, 5 is upper R. The plane window is padded to a
  // power of two so the plane counter indexes it without range issues.
  always_comb begin : plane_select
    logic [COLOR_BITS-1:0]     chan;
    logic [(1<<PLANE_W)-1:0]   top;
    plane_bits = '0;
    for (int k = 0; k < 6; k++) begin
      chan = pix_rdata[k*COLOR_BITS +: COLOR_BITS];
      top = '0;
      top[PLANES-1:0] = chan[COLOR_BITS-1 -: PLANES];
      plane_bits[k] = top[plane];
    end
  end

  // Next state and next counter values. Counters for a state are cleared
  // on entry, so every state starts counting from zero.
  always_comb begin
    next_state = state;
    row_n      = row;
    plane_n    = plane;
    col_n      = col;
    slot_n     = slot;
    cnt_n      = cnt;
    disp_last  = CNT_W'((BASE_OE_CYCLES << plane) - 1);
    case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_PREFETCH;
          row_n      = '0;
          plane_n    = '0;
        end
      end
      ST_PREFETCH: begin
        next_state = ST_SHIFT;
        col_n      = '0;
        slot_n     = '0;
      end
      ST_SHIFT: begin
        if (slot == SLOT_LAST) begin
          slot_n = '0;
          if (col == COL_LAST) begin
            next_state = ST_LATCH;
            cnt_n      = '0;
          end else begin
            col_n = col + 1'b1;
          end
        end else begin
          slot_n = slot + 1'b1;
        end
      end
      ST_LATCH: begin
        if (cnt == CNT_W'(1)) begin
          next_state = ST_DISPLAY;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DISPLAY: begin
        if (cnt == disp_last) begin
          cnt_n = '0;
          if (plane == PLANE_LAST) begin
            plane_n = '0;
            row_n   = row + 1'b1;
          end else begin
            plane_n = plane + 1'b1;
          end
          // End of frame is the last plane of the last row.
          if (plane == PLANE_LAST && row == '1 && !enable)
            next_state = ST_IDLE;
          else
            next_state = ST_PREFETCH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from where the scanner
  // will be in the next cycle. The read for column c+1 is issued in the
  // last cycle of slot c so its data lands at slot cycle 0 of column c+1.
  always_comb begin
    busy_d        = (next_state != ST_IDLE);
    frame_start_d = (next_state == ST_PREFETCH) && (row_n == '0) && (plane_n == '0);
    pix_en_d      = 1'b0;
    pix_addr_d    = pix_addr;
    if (next_state == ST_PREFETCH) begin
      pix_en_d   = 1'b1;
      pix_addr_d = {row_n, COL_W'(0)};
    end else if (next_state == ST_SHIFT && slot_n == SLOT_LAST && col_n != COL_LAST) begin
      pix_en_d   = 1'b1;
      pix_addr_d = {row_n, COL_W'(col_n + 1'b1)};
    end
    clk_d     = (next_state == ST_SHIFT) && (slot_n >= CLK_HI);
    lat_d     = (next_state == ST_LATCH);
    oe_d      = (next_state != ST_DISPLAY);
    row_out_d = (next_state == ST_LATCH) ? row_n : hub75io_row;
  end

  // State, counters and all output registers. Colour data is captured at
  // slot cycle 0 and so is stable a cycle before the rising shift clock.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      row         <= '0;
      plane       <= '0;
      col         <= '0;
      slot        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      pix_en      <= 1'b0;
      pix_addr    <= '0;
      hub75io_clk <= 1'b0;
      hub75io_r   <= '0;
      hub75io_g   <= '0;
      hub75io_b   <= '0;
      hub75io_row <= '0;
      hub75io_lat <= 1'b0;
      hub75io_oe  <= 1'b1;
    end else begin
      state       <= next_state;
      row         <= row_n;
      plane       <= plane_n;
      col         <= col_n;
      slot        <= slot_n;
      cnt         <= cnt_n;
      busy        <= busy_d;
      frame_start <= frame_start_d;
      pix_en      <= pix_en_d;
      pix_addr    <= pix_addr_d;
      hub75io_clk <= clk_d;
      hub75io_row <= row_out_d;
      hub75io_lat <= lat_d;
      hub75io_oe  <= oe_d;
      if (state == ST_SHIFT && slot == '0) begin
        hub75io_r <= {plane_bits[2], plane_bits[5]};
        hub75io_g <= {plane_bits[1], plane_bits[4]};
        hub75io_b <= {plane_bits[0], plane_bits[3]};
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// tb_hub75_bcm_driver
//
// Directed bench for hub75_bcm_driver with a 4-column, 2-scan-row, 2-plane
// configuration. A small frame-buffer memory answers pix_en one cycle later.
// Outputs are sampled on the falling clock edge and panel events (frame
// starts, blanking runs, latched rows, shift-clock edges, reads) are logged
// for comparison against hand-computed sequences.
module tb_hub75_bcm_driver;

  localparam int COLUMNS        = 4;
  localparam int ROW_ADDR_BITS  = 1;
  localparam int COLOR_BITS     = 4;
  localparam int PLANES         = 2;
  localparam int CLOCK_DIV      = 2;
  localparam int BASE_OE_CYCLES = 4;

  // Expected read address trace of one frame.
  localparam int EXP_ADDR [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
  // Expected {r,g,b} at each shift-clock rise, pattern A (uR=4, lB=8).
  localparam int EXP_RISE_A [16] = '{'h10, 'h10, 'h10, 'h10, 'h02, 'h02, 'h02, 'h02,
                                     'h10, 'h10, 'h10, 'h10, 'h02, 'h02, 'h02, 'h02};
  // Expected {r,g,b} at each shift-clock rise, pattern B (uG = column<<2).
  localparam int EXP_RISE_B [16] = '{0, 4, 0, 4, 0, 0, 4, 4, 0, 4, 0, 4, 0, 0, 4, 4};
  localparam int EXP_OE [8]   = '{4, 8, 4, 8, 4, 8, 4, 8};
  localparam int EXP_ROW [4]  = '{0, 0, 1, 1};

  logic        clock;
  logic        aresetn;
  logic        enable;
  logic        busy;
  logic        frame_start;
  logic        pix_en;
  logic [2:0]  pix_addr;
  logic [23:0] pix_rdata = '0;
  logic        hub75io_clk;
  logic [1:0]  hub75io_r;
  logic [1:0]  hub75io_g;
  logic [1:0]  hub75io_b;
  logic [0:0]  hub75io_row;
  logic        hub75io_lat;
  logic        hub75io_oe;

  logic [23:0] fb [8];

  int num_compared   = 0;
  int num_mismatched = 0;

  int         cyc;
  int         fs_q[$];
  int         oe_q[$];
  int         row_q[$];
  int         addr_q[$];
  logic [5:0] rise_q[$];
  int         unstable;
  int         overlap;
  int         oe_run;
  logic       prev_clk;
  logic       prev_lat;
  logic [5:0] prev_rgb;

  hub75_bcm_driver #(
    .COLUMNS(COLUMNS),
    .ROW_ADDR_BITS(ROW_ADDR_BITS),
    .COLOR_BITS(COLOR_BITS),
    .PLANES(PLANES),
    .CLOCK_DIV(CLOCK_DIV),
    .BASE_OE_CYCLES(BASE_OE_CYCLES)
  ) dut (
    .clock(clock),
    .aresetn(aresetn),
    .enable(enable),
    .busy(busy),
    .frame_start(frame_start),
    .pix_en(pix_en),
    .pix_addr(pix_addr),
    .pix_rdata(pix_rdata),
    .hub75io_clk(hub75io_clk),
    .hub75io_r(hub75io_r),
    .hub75io_g(hub75io_g),
    .hub75io_b(hub75io_b),
    .hub75io_row(hub75io_row),
    .hub75io_lat(hub75io_lat),
    .hub75io_oe(hub75io_oe)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous frame buffer with one cycle of read latency.
  always @(posedge clock) begin
    if (pix_en) pix_rdata <= fb[pix_addr];
  end

  // Count a comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_compared++;
    if (obs !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] allOutputs();
    return {busy, frame_start, pix_en, pix_addr, hub75io_clk, hub75io_r, hub75io_g,
            hub75io_b, hub75io_row, hub75io_lat, hub75io_oe};
  endfunction

  task automatic clearRecord();
    fs_q.delete();
    oe_q.delete();
    row_q.delete();
    addr_q.delete();
    rise_q.delete();
    unstable = 0;
    overlap  = 0;
    oe_run   = 0;
    cyc      = 0;
    prev_clk = hub75io_clk;
    prev_lat = hub75io_lat;
    prev_rgb = {hub75io_r, hub75io_g, hub75io_b};
  endtask

  // Advance the given number of cycles, logging panel events at each
  // falling edge.
  task automatic applyStimulus(input int cycles);
    logic [5:0] rgb;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      cyc++;
      rgb = {hub75io_r, hub75io_g, hub75io_b};
      if (frame_start) fs_q.push_back(cyc);
      if (pix_en) addr_q.push_back(int'(pix_addr));
      if (hub75io_lat && !prev_lat) row_q.push_back(int'(hub75io_row));
      if (hub75io_clk && !prev_clk) begin
        rise_q.push_back(rgb);
        if (rgb !== prev_rgb) unstable++;
      end
      if (!hub75io_oe) begin
        oe_run++;
        if (hub75io_lat || hub75io_clk) overlap++;
      end else if (oe_run > 0) begin
        oe_q.push_back(oe_run);
        oe_run = 0;
      end
      prev_clk = hub75io_clk;
      prev_lat = hub75io_lat;
      prev_rgb = rgb;
    end
  endtask

  task automatic doReset();
    aresetn = 1'b0;
    enable  = 1'b0;
    applyStimulus(2);
  endtask

  task automatic checkFrameLog(input string tag, input int n_oe);
    for (int i = 0; i < n_oe; i++)
      checkOutput($sformatf("%s_oe_run%0d", tag, i), (i < oe_q.size()) ? oe_q[i] : -1, EXP_OE[i]);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_lat_row%0d", tag, i), (i < row_q.size()) ? row_q[i] : -1, EXP_ROW[i]);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("%s_addr%0d", tag, i), (i < addr_q.size()) ? addr_q[i] : -1, EXP_ADDR[i]);
    checkOutput({tag, "_overlap"}, overlap, 0);
    checkOutput({tag, "_unstable"}, unstable, 0);
  endtask

  initial begin
    // Pattern A: upper R = 4, lower B = 8 everywhere.
    for (int a = 0; a < 8; a++) fb[a] = 24'h400008;

    $display("[TB] reset and single-cycle enable");
    doReset();
    checkOutput("reset_outputs", allOutputs(), 16'h0001);
    aresetn = 1'b1;
    enable  = 1'b1;
    clearRecord();
    applyStimulus(1);
    enable = 1'b0;
    checkOutput("start_frame_start", frame_start, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_fetch", {pix_en, pix_addr}, 4'b1000);
    applyStimulus(99);
    checkOutput("frame_end_busy", busy, 1);
    applyStimulus(1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_oe", hub75io_oe, 1);
    applyStimulus(10);
    checkOutput("single_fs_count", fs_q.size(), 1);
    checkOutput("single_addr_count", addr_q.size(), 16);
    checkOutput("single_rise_count", rise_q.size(), 16);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("rgbA_rise%0d", i), (i < rise_q.size()) ? rise_q[i] : 6'h3f,
                  EXP_RISE_A[i]);
    checkFrameLog("single", 4);

    $display("[TB] continuous run");
    // Pattern B: upper G carries the column number in bits 3:2.
    for (int a = 0; a < 8; a++) fb[a] = {4'h0, 2'(a), 2'b00, 16'h0000};
    doReset();
    aresetn = 1'b1;
    enable  = 1'b1;
    clearRecord();
    applyStimulus(250);
    checkOutput("cont_fs_count", fs_q.size(), 3);
    checkOutput("cont_fs_first", (fs_q.size() > 0) ? fs_q[0] : -1, 1);
    checkOutput("cont_fs_gap1", (fs_q.size() > 1) ? fs_q[1] - fs_q[0] : -1, 100);
    checkOutput("cont_fs_gap2", (fs_q.size() > 2) ? fs_q[2] - fs_q[1] : -1, 100);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("rgbB_rise%0d", i), (i < rise_q.size()) ? rise_q[i] : 6'h3f,
                  EXP_RISE_B[i]);
    checkFrameLog("cont", 8);

    $display("[TB] reset during row 1 shift");
    doReset();
    aresetn = 1'b1;
    enable  = 1'b1;
    clearRecord();
    applyStimulus(1);
    enable = 1'b0;
    applyStimulus(57);
    checkOutput("midshift_state", {busy, hub75io_oe, pix_addr}, 5'b11101);
    aresetn = 1'b0;
    applyStimulus(1);
    checkOutput("midshift_reset_outputs", allOutputs(), 16'h0001);

    $display("[TB] restart, enable dropped during row 0");
    aresetn = 1'b1;
    enable  = 1'b1;
    clearRecord();
    applyStimulus(1);
    checkOutput("restart_fetch", {frame_start, pix_en, pix_addr}, 5'b11000);
    applyStimulus(9);
    enable = 1'b0;
    applyStimulus(120);
    checkOutput("drop_fs_count", fs_q.size(), 1);
    checkOutput("drop_addr_count", addr_q.size(), 16);
    checkOutput("drop_busy", busy, 0);
    checkFrameLog("drop", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
